// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU.
//   - opcode encodings for ALUOP
//   - FSM state enum (IDLE / EXEC / DONE)
//   - helper to classify opcodes that iterate in EXEC
package alu_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;  // result = B
    localparam logic [2:0] OP_ADD = 3'b001;  // A + B
    localparam logic [2:0] OP_AND = 3'b010;  // A & B
    localparam logic [2:0] OP_OR  = 3'b011;  // A | B
    localparam logic [2:0] OP_SUB = 3'b100;  // A - B
    localparam logic [2:0] OP_MUL = 3'b101;  // low WIDTH bits of A * B
    localparam logic [2:0] OP_SLL = 3'b110;  // A << amt, zero fill
    localparam logic [2:0] OP_SRA = 3'b111;  // A >>> amt, sign fill

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Opcodes whose EXEC phase spans more than one cycle in general.
    function automatic logic is_iterative(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_SLL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations (FORWARD, ADD, AND, OR, SUB).
// Ports:
//   a, b      in  WIDTH  signed operands
//   op        in  3      opcode (alu_pkg encodings)
//   result    out WIDTH  wrap-around result; 0 for opcodes not handled here
//   overflow  out 1      signed overflow of ADD/SUB; 0 otherwise
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum      = a + b;
        diff     = a - b;
        result   = '0;
        overflow = 1'b0;
        case (op)
            OP_FWD: result = b;
            OP_ADD: begin
                result   = sum;
                // Like-signed operands producing an opposite-signed sum.
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_SUB: begin
                result   = diff;
                // Unlike-signed operands where the difference flips sign from A.
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                result   = '0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops go through alu_comb; MUL (shift-add, one bit per cycle)
// and SLL/SRA (one bit position per cycle) iterate here.
// Ports:
//   CLK        in   1      clock, rising edge
//   RESET_N    in   1      asynchronous active-low reset
//   IN_VALID   in   1      request valid
//   IN_READY   out  1      high in IDLE only
//   OPERAND1   in   WIDTH  operand A
//   OPERAND2   in   WIDTH  operand B / shift amount in [SHAMT_W-1:0]
//   ALUOP      in   3      opcode
//   OUT_VALID  out  1      high in DONE only
//   OUT_READY  in   1      consumer accepts result
//   ALURESULT  out  WIDTH  result, held between operations
//   ZERO       out  1      ALURESULT == 0
//   OVERFLOW   out  1      signed overflow of ADD/SUB
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] OPERAND1,
    input  logic [WIDTH-1:0] OPERAND2,
    input  logic [2:0]       ALUOP,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] ALURESULT,
    output logic             ZERO,
    output logic             OVERFLOW
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t state;
    state_t next_state;

    logic             accept;
    logic             last;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] acc;      // MUL partial product
    logic [WIDTH-1:0] work;     // MUL shifted multiplicand / shift operand
    logic [WIDTH-1:0] mplier;   // MUL multiplier, consumed LSB first
    logic [CNT_W-1:0] cnt;      // EXEC cycles remaining

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;

    logic [SHAMT_W-1:0] amt_in;
    logic [CNT_W-1:0]   cnt_load;
    logic               amt_zero;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   work_next;
    logic [WIDTH-1:0]   res_final;

    logic [WIDTH-1:0] comb_result;
    logic             comb_overflow;

    alu_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .a        (a_reg),
        .b        (b_reg),
        .op       (op_reg),
        .result   (comb_result),
        .overflow (comb_overflow)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        IN_READY   = 1'b0;
        OUT_VALID  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    accept     = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                OUT_VALID = 1'b1;
                // Return to IDLE only; IN_READY is low here so a request
                // cannot be taken on the handshake edge.
                if (OUT_READY) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------- EXEC length at accept ----------------
    always_comb begin
        amt_in   = OPERAND2[SHAMT_W-1:0];
        cnt_load = CNT_W'(1);
        if (ALUOP == OP_MUL) begin
            cnt_load = CNT_W'(WIDTH);
        end else if (is_iterative(ALUOP) && (amt_in != '0)) begin
            cnt_load = CNT_W'(amt_in);
        end
    end

    assign last = (cnt == CNT_W'(1));

    // ---------------- iteration step ----------------
    always_comb begin
        amt_zero  = (b_reg[SHAMT_W-1:0] == '0);
        acc_next  = mplier[0] ? (acc + work) : acc;
        work_next = work;
        case (op_reg)
            OP_MUL: work_next = work << 1;
            OP_SLL: if (!amt_zero) work_next = work << 1;
            OP_SRA: if (!amt_zero) work_next = {work[WIDTH-1], work[WIDTH-1:1]};
            default: work_next = work;
        endcase

        case (op_reg)
            OP_MUL:         res_final = acc_next;
            OP_SLL, OP_SRA: res_final = work_next;
            default:        res_final = comb_result;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            acc      <= '0;
            work     <= '0;
            mplier   <= '0;
            cnt      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_reg  <= OPERAND1;
            b_reg  <= OPERAND2;
            op_reg <= ALUOP;
            acc    <= '0;
            work   <= OPERAND1;
            mplier <= OPERAND2;
            cnt    <= cnt_load;
        end else if (state == EXEC) begin
            acc    <= acc_next;
            work   <= work_next;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
            if (last) begin
                result_q <= res_final;
                zero_q   <= (res_final == '0);
                // alu_comb reports 0 for MUL and the shifts.
                ovf_q    <= comb_overflow;
            end
        end
    end

    assign ALURESULT = result_q;
    assign ZERO      = zero_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=8): directed vectors push
// expected results; a negedge monitor compares each presented output.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] op1 = '0;
    logic [7:0] op2 = '0;
    logic [2:0] aluop = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] alu_result;
    logic       zero;
    logic       overflow;

    alu_multicycle #(
        .WIDTH(8)
    ) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .OPERAND1  (op1),
        .OPERAND2  (op2),
        .ALUOP     (aluop),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .ALURESULT (alu_result),
        .ZERO      (zero),
        .OVERFLOW  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       o;
        int         lat;
        int         acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   prev_valid = 1'b0;
    bit   have_cur = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare on first cycle of OUT_VALID, then check hold while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            have_cur   = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'd0);
                    have_cur = 1'b0;
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                    check("result",   32'(alu_result), 32'(cur.res));
                    check("zero",     32'(zero),       32'(cur.z));
                    check("overflow", 32'(overflow),   32'(cur.o));
                    check("latency",  32'(cyc - cur.acc_cyc), 32'(cur.lat));
                end
            end else if (out_valid && prev_valid && have_cur) begin
                check("hold_result",   32'(alu_result), 32'(cur.res));
                check("hold_zero",     32'(zero),       32'(cur.z));
                check("hold_overflow", 32'(overflow),   32'(cur.o));
                check("hold_in_ready", 32'(in_ready),   32'd0);
            end
            prev_valid = out_valid;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic ez, input logic eo,
                         input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        check("ready_before_issue", 32'(in_ready), 32'd1);
        aluop    = op;
        op1      = a;
        op2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            e.res = er; e.z = ez; e.o = eo; e.lat = lat; e.acc_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("wait_done_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        check("wait_valid_timeout", 32'd1, 32'd0);
    endtask

    task automatic run(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic ez, input logic eo, input int lat);
        issue(op, a, b, er, ez, eo, lat, 1'b1);
        wait_done();
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_result",    32'(alu_result), 32'd0);
        check("rst_zero",      32'(zero),       32'd0);
        check("rst_overflow",  32'(overflow),   32'd0);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_in_ready",  32'(in_ready),   32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        //   op      A      B      result z     o     lat
        run(OP_FWD, 8'h00, 8'd65, 8'd65,  1'b0, 1'b0, 1);
        run(OP_ADD, 8'd100,8'd50, 8'h96,  1'b0, 1'b1, 1);
        run(OP_SUB, 8'd5,  8'd5,  8'h00,  1'b1, 1'b0, 1);
        run(OP_AND, 8'hF0, 8'h3C, 8'h30,  1'b0, 1'b0, 1);
        run(OP_OR,  8'hF0, 8'h0C, 8'hFC,  1'b0, 1'b0, 1);
        run(OP_SUB, 8'h80, 8'h01, 8'h7F,  1'b0, 1'b1, 1);
        run(OP_ADD, 8'hFF, 8'h01, 8'h00,  1'b1, 1'b0, 1);
        run(OP_MUL, 8'hFD, 8'd7,  8'hEB,  1'b0, 1'b0, 8);
        run(OP_MUL, 8'd16, 8'd16, 8'h00,  1'b1, 1'b0, 8);
        run(OP_MUL, 8'd12, 8'd11, 8'h84,  1'b0, 1'b0, 8);
        run(OP_SLL, 8'h03, 8'd3,  8'h18,  1'b0, 1'b0, 3);
        run(OP_SRA, 8'h80, 8'd7,  8'hFF,  1'b0, 1'b0, 7);
        run(OP_SRA, 8'h80, 8'd0,  8'h80,  1'b0, 1'b0, 1);
        run(OP_SLL, 8'h81, 8'h09, 8'h02,  1'b0, 1'b0, 1);
        run(OP_SRA, 8'h40, 8'd2,  8'h10,  1'b0, 1'b0, 2);

        // Backpressure: result held 5 cycles, IN_VALID pulses ignored
        out_ready = 1'b0;
        issue(OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1, 1'b1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            aluop    = OP_FWD;
            op1      = 8'(i);
            op2      = 8'h55;
            in_valid = i[0];
            @(negedge clk);
        end
        // IN_VALID held high across the handshake edge must not be taken
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        check("bp_idle_in_ready",  32'(in_ready),  32'd1);
        in_valid = 1'b0;

        run(OP_SLL, 8'h03, 8'd3, 8'h18, 1'b0, 1'b0, 3);

        // Reset on the 3rd cycle of a MUL: aborted, no output
        issue(OP_MUL, 8'd3, 8'd5, 8'd0, 1'b0, 1'b0, 8, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_result",    32'(alu_result), 32'd0);
        check("abort_zero",      32'(zero),       32'd0);
        check("abort_overflow",  32'(overflow),   32'd0);
        check("abort_out_valid", 32'(out_valid),  32'd0);
        check("abort_in_ready",  32'(in_ready),   32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run(OP_FWD, 8'h00, 8'd9, 8'd9, 1'b0, 1'b0, 1);

        repeat (12) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; the block SHALL support WIDTH >= 4.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH): shift-amount field width; it SHALL be derived from WIDTH and not overridden.
REQ-003 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 RESET_N  in  1  reset, asynchronous and active-low.
REQ-005 IN_VALID  in  1  request valid.
REQ-006 IN_READY  out  1  block can accept a request.
REQ-007 OPERAND1  in  WIDTH  signed operand A.
REQ-008 OPERAND2  in  WIDTH  signed operand B, or shift amount in bits [SHAMT_W-1:0].
REQ-009 ALUOP  in  3  operation select.
REQ-010 OUT_VALID  out  1  result valid.
REQ-011 OUT_READY  in  1  consumer accepts the result.
REQ-012 ALURESULT  out  WIDTH  signed result.
REQ-013 ZERO  out  1  ALURESULT == 0.
REQ-014 OVERFLOW  out  1  signed overflow of ADD/SUB.

Function
REQ-015 Opcodes SHALL be: 000 FORWARD (B), 001 ADD (A+B), 010 AND, 011 OR, 100 SUB (A-B), 101 MUL (low WIDTH bits of A*B), 110 SLL (A << amt, zero fill), 111 SRA (A >>> amt, sign fill).
REQ-016 The FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-017 IDLE: IN_READY=1; IN_VALID=1 SHALL capture OPERAND1, OPERAND2 and ALUOP and move to EXEC; IN_VALID=0 SHALL keep IDLE.
REQ-018 IN_READY SHALL be 0 in EXEC and DONE; IN_VALID and operand changes in those states SHALL be ignored.
REQ-019 FORWARD/ADD/AND/OR/SUB: EXEC SHALL last one cycle; OUT_VALID SHALL rise exactly 1 cycle after the accept edge.
REQ-020 MUL: iterative shift-add, one multiplier bit per cycle, WIDTH cycles in EXEC; OUT_VALID SHALL rise exactly WIDTH cycles after accept; the result SHALL equal the two's-complement product mod 2^WIDTH.
REQ-021 SLL/SRA: one bit position per cycle; OUT_VALID SHALL rise exactly max(amt,1) cycles after accept; amt=0 SHALL return A unchanged.
REQ-022 ADD/SUB SHALL be WIDTH-bit wrap-around; OVERFLOW=1 iff the operand signs make the signed result unrepresentable; OVERFLOW=0 for all other ops.
REQ-023 ZERO SHALL be valid for every op whenever OUT_VALID=1.
REQ-024 DONE: OUT_VALID=1; ALURESULT, ZERO and OVERFLOW SHALL hold stable until OUT_READY=1, then the block SHALL return to IDLE on that edge.
REQ-025 No new request SHALL be accepted on the same edge as the output handshake; the minimum request-to-request spacing SHALL be latency+2 cycles.
REQ-026 Outside DONE, OUT_VALID SHALL be 0 and ALURESULT, ZERO and OVERFLOW SHALL hold their last values.

Reset
REQ-027 RESET_N=0 SHALL immediately force IDLE and clear ALURESULT, ZERO, OVERFLOW, OUT_VALID and all internal registers to 0, with IN_READY=1.
REQ-028 Reset mid-EXEC or mid-DONE SHALL abort the operation with no result emitted; the first accept SHALL be possible on the first rising edge after RESET_N rises.

Structure
REQ-029 Shared package alu_pkg SHALL hold the opcode localparams and the state enum (IDLE/EXEC/DONE).
REQ-030 The single-cycle ops SHALL live in one sub-module alu_comb (A, B, op -> result, overflow); MUL, the shifts and the FSM SHALL stay in alu_multicycle.

Verification (WIDTH=8)
REQ-031 FORWARD A=0, B=65 -> ALURESULT=65, ZERO=0, OUT_VALID 1 cycle after accept.
REQ-032 ADD 100+50 -> 8'h96, OVERFLOW=1; SUB 5-5 -> 0, ZERO=1, OVERFLOW=0.
REQ-033 MUL -3*7 -> 8'hEB (-21), OUT_VALID exactly 8 cycles after accept; MUL 16*16 -> 0, ZERO=1.
REQ-034 SLL 8'b00000011 by 3 -> 8'b00011000 after 3 cycles; SRA 8'h80 by 7 -> 8'hFF after 7 cycles; SRA 8'h80 by 0 -> 8'h80 after 1 cycle.
REQ-035 Backpressure: OUT_READY low for 5 cycles -> result stable, IN_READY=0, IN_VALID pulses ignored; OUT_READY=1 -> IDLE next cycle.
REQ-036 RESET_N low on the 3rd cycle of MUL -> outputs 0 at once, no OUT_VALID; after release a FORWARD 9 -> 9.
